// File: rtl/yc_pkg.sv
// yc_pkg: state encoding, chroma mid-scale and luma saturation shared by the Y/C blocks
package yc_pkg;

    typedef enum logic [2:0] {IDLE, BLANK, ACTIVE, FALL, TIP, RISE, LOS} yc_state_e;

    localparam logic [7:0] C_MID = 8'd128;

    function automatic logic [7:0] sat8(input logic [9:0] v);
        return (v > 10'd255) ? 8'd255 : v[7:0];
    endfunction

endpackage

// File: rtl/yc_chroma_fir3.sv
// yc_chroma_fir3: [1,2,1]/4 chroma low-pass with mid-scale history preload
module yc_chroma_fir3
    import yc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       preload,
    input  logic [7:0] c_in,
    output logic [7:0] c_out
);

    logic [7:0] h1, h2;
    logic [9:0] sum;
    logic [1:0] lsb_unused;

    // shift the two history taps, or refill them with mid-scale so no sync-time chroma leaks out
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            h1 <= C_MID;
            h2 <= C_MID;
        end else begin
            h1 <= preload ? C_MID : c_in;
            h2 <= preload ? C_MID : h1;
        end

    assign sum = {2'b0, c_in} + {1'b0, h1, 1'b0} + {2'b0, h2} + 10'd2;
    assign {c_out, lsb_unused} = sum;

endmodule

// File: rtl/yc_level_encoder.sv
// yc_level_encoder: inserts sync/blank/setup levels and filters chroma into DAC codes
module yc_level_encoder
    import yc_pkg::*;
#(
    parameter logic [7:0]  BLANK_LVL = 8'd72,
    parameter logic [7:0]  SETUP_LVL = 8'd10,
    parameter logic [7:0]  Y_GAIN    = 8'd176,
    parameter int          RAMP_LOG2 = 2,
    parameter logic [19:0] LOS_CLKS  = 20'd200000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        PAL_EN,
    input  logic        CVBS,
    input  logic        SETUP_EN,
    input  logic [23:0] din,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        csync,
    input  logic        de,
    output logic [23:0] dout,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        csync_o,
    output logic        de_o
);

    localparam int SW = RAMP_LOG2 + 1;
    localparam logic [SW-1:0] STEPS = SW'(1 << RAMP_LOG2);

    logic [7:0]    s1_y, s1_c, pad_unused, fir_c, c_lvl, ramp_lvl;
    logic          s1_hs, s1_vs, s1_cs, s1_de, s1_pal, s1_cvbs, s1_setup;
    logic          hs_rise, cs_rise, cs_fall, in_ramp, preload, kill;
    yc_state_e     st, nxt;
    logic [SW-1:0] step, step_n;
    logic [19:0]   los_cnt, los_n;
    logic [15:0]   ramp_prod, y_prod;
    logic [9:0]    y_act, y_lvl, s2_y;
    logic [7:0]    s2_c;
    logic [3:0]    s2_sync;

    assign pad_unused = din[7:0];

    // S1: capture pixel, syncs and mode pins; flag sync edges against the previous sample
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            s1_y <= '0;
            s1_c <= C_MID;
            {s1_hs, s1_vs, s1_cs, s1_de} <= '0;
            {s1_pal, s1_cvbs, s1_setup} <= '0;
            {hs_rise, cs_rise, cs_fall} <= '0;
        end else begin
            s1_y <= din[15:8];
            s1_c <= din[23:16];
            {s1_hs, s1_vs, s1_cs, s1_de} <= {hsync, vsync, csync, de};
            {s1_pal, s1_cvbs, s1_setup} <= {PAL_EN, CVBS, SETUP_EN};
            hs_rise <= hsync & ~s1_hs;
            cs_rise <= csync & ~s1_cs;
            cs_fall <= ~csync & s1_cs;
        end

    // state, ramp step and loss-of-signal counter advance once per S1 sample
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            st <= IDLE;
            step <= '0;
            los_cnt <= '0;
        end else begin
            st <= nxt;
            step <= step_n;
            los_cnt <= los_n;
        end

    // next state; ramps reverse from the current step so the level never jumps
    always_comb begin
        nxt = st;
        step_n = step;
        los_n = hs_rise ? '0 : (los_cnt == LOS_CLKS) ? los_cnt : los_cnt + 20'd1;
        case (st)
            IDLE:          if (hs_rise) nxt = BLANK;
            BLANK, ACTIVE: if (cs_rise) begin
                               nxt = FALL;
                               step_n = SW'(1);
                           end else nxt = s1_de ? ACTIVE : BLANK;
            FALL, TIP, RISE:
                if (cs_fall || (st == RISE && !cs_rise)) begin
                    step_n = step - SW'(1);
                    nxt = (step_n == '0) ? BLANK : RISE;
                end else if (st != TIP) begin
                    step_n = step + SW'(1);
                    nxt = (step_n == STEPS) ? TIP : FALL;
                end
            LOS:           if (hs_rise) nxt = BLANK;
            default:       nxt = IDLE;
        endcase
        if (st != IDLE && !hs_rise && los_n == LOS_CLKS) begin
            nxt = LOS;
            step_n = '0;
        end
    end

    assign ramp_prod = 16'(BLANK_LVL) * 16'(step_n);
    assign ramp_lvl  = BLANK_LVL - 8'(ramp_prod >> RAMP_LOG2);
    assign y_prod    = 16'(s1_y) * 16'(Y_GAIN);
    assign y_act     = 10'(BLANK_LVL) + ((s1_setup & ~s1_pal) ? 10'(SETUP_LVL) : 10'd0) + 10'(y_prod >> 8);
    assign in_ramp   = nxt inside {FALL, TIP, RISE};
    assign y_lvl     = (nxt == ACTIVE) ? y_act : 10'(in_ramp ? ramp_lvl : BLANK_LVL);
    assign c_lvl     = s1_cvbs ? 8'd0 : (nxt == ACTIVE || nxt == BLANK) ? fir_c : C_MID;
    assign preload   = nxt == FALL && st != FALL;
    assign kill      = nxt == LOS;

    yc_chroma_fir3 u_fir (
        .clk     (clk),
        .reset_n (reset_n),
        .preload (preload),
        .c_in    (s1_c),
        .c_out   (fir_c)
    );

    // S2: hold the unsaturated luma level, selected chroma and syncs (muted on loss of signal)
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            s2_y <= 10'(BLANK_LVL);
            s2_c <= C_MID;
            s2_sync <= '0;
        end else begin
            s2_y <= y_lvl;
            s2_c <= c_lvl;
            s2_sync <= kill ? 4'd0 : {s1_hs, s1_vs, s1_cs, s1_de};
        end

    // S3: saturate luma and register the DAC word with matching syncs
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            dout <= {C_MID, BLANK_LVL, 8'd0};
            {hsync_o, vsync_o, csync_o, de_o} <= '0;
        end else begin
            dout <= {s2_c, sat8(s2_y), 8'd0};
            {hsync_o, vsync_o, csync_o, de_o} <= s2_sync;
        end

endmodule

// File: tb/tb_yc_level_encoder.sv
// tb_yc_level_encoder: directed vectors with a queued scoreboard for yc_level_encoder
module tb_yc_level_encoder;

    logic        clk = 0, reset_n = 0, pal = 0, cvbs = 0, setup_en = 1;
    logic [23:0] din = '0;
    logic        hsync = 0, vsync = 0, csync = 0, de = 0;
    logic [23:0] dout;
    logic        hsync_o, vsync_o, csync_o, de_o;
    logic [27:0] act;
    int          cyc = 0, n_chk = 0, n_pass = 0;

    typedef struct {
        int          at;
        logic [27:0] exp;
        string       nm;
    } exp_t;
    exp_t q[$];

    yc_level_encoder #(.LOS_CLKS(20'd40)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .PAL_EN   (pal),
        .CVBS     (cvbs),
        .SETUP_EN (setup_en),
        .din      (din),
        .hsync    (hsync),
        .vsync    (vsync),
        .csync    (csync),
        .de       (de),
        .dout     (dout),
        .hsync_o  (hsync_o),
        .vsync_o  (vsync_o),
        .csync_o  (csync_o),
        .de_o     (de_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign act = {dout, hsync_o, vsync_o, csync_o, de_o};

    task automatic check(input string nm, input logic [27:0] got, input logic [27:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got {dout,hs,vs,cs,de}=%h expected %h", nm, got, want);
    endtask

    // drive one pixel now (at a falling edge); expected output is due 3 cycles later
    task automatic px(input logic [7:0] y, input logic [7:0] c, input logic hs, input logic cs,
                      input logic d, input logic chk, input logic [7:0] ey, input logic [7:0] ec,
                      input logic kill, input string nm);
        din = {c, y, 8'd0};
        hsync = hs;
        csync = cs;
        de = d;
        if (chk) q.push_back('{cyc + 3, {ec, ey, 8'd0, kill ? 4'd0 : {hs, vsync, cs, d}}, nm});
        @(negedge clk);
    endtask

    // monitor: compare whatever output the queue head is waiting for
    always @(negedge clk)
        while (q.size() > 0 && q[0].at <= cyc) begin
            exp_t e;
            e = q.pop_front();
            check(e.nm, act, e.exp);
        end

    initial begin
        logic [7:0] fall_v[5] = '{8'd54, 8'd36, 8'd18, 8'd0, 8'd0};
        logic [7:0] rise_v[4] = '{8'd18, 8'd36, 8'd54, 8'd72};
        repeat (2) @(posedge clk);
        #1 check("reset_state", act, {24'h804800, 4'h0});
        @(negedge clk);
        reset_n = 1;
        repeat (3) px(255, 200, 0, 0, 1, 1, 72, 128, 0, "idle_hold");
        repeat (2) px(255, 128, 0, 0, 1, 1, 72, 128, 0, "idle_hold2");
        px(0, 128, 1, 0, 0, 1, 72, 128, 0, "hs_rise_blank");
        px(0, 128, 0, 0, 0, 1, 72, 128, 0, "blank");
        foreach (fall_v[i]) px(0, 128, 1, 1, 0, 1, fall_v[i], 128, 0, "ramp_fall");
        foreach (rise_v[i]) px(0, 128, 0, 0, 0, 1, rise_v[i], 128, 0, "ramp_rise");
        px(0, 128, 1, 1, 0, 1, 54, 128, 0, "rev_fall1");
        px(0, 128, 1, 1, 0, 1, 36, 128, 0, "rev_fall2");
        px(0, 128, 0, 0, 0, 1, 54, 128, 0, "rev_rise1");
        px(0, 128, 0, 0, 0, 1, 72, 128, 0, "rev_blank");
        px(0, 128, 1, 0, 0, 1, 72, 128, 0, "hs_pulse");
        px(255, 128, 0, 0, 1, 1, 255, 128, 0, "act_ntsc_sat");
        pal = 1;
        px(255, 128, 0, 0, 1, 1, 247, 128, 0, "act_pal");
        pal = 0;
        setup_en = 0;
        px(255, 128, 0, 0, 1, 1, 247, 128, 0, "act_nosetup");
        setup_en = 1;
        px(0, 128, 0, 0, 1, 1, 82, 128, 0, "act_y0");
        px(128, 128, 0, 0, 1, 1, 170, 128, 0, "act_y128");
        px(0, 128, 0, 0, 1, 1, 82, 128, 0, "fir_0");
        px(0, 200, 0, 0, 1, 1, 82, 146, 0, "fir_1");
        px(0, 200, 0, 0, 1, 1, 82, 182, 0, "fir_2");
        px(0, 200, 0, 0, 1, 1, 82, 200, 0, "fir_3");
        cvbs = 1;
        px(0, 60, 0, 0, 1, 1, 82, 0, 0, "cvbs_act");
        px(0, 200, 0, 0, 0, 1, 72, 0, 0, "cvbs_blank");
        px(0, 128, 1, 1, 0, 1, 54, 0, 0, "cvbs_fall");
        px(0, 128, 0, 0, 0, 1, 72, 0, 0, "cvbs_back");
        cvbs = 0;
        repeat (2) px(0, 128, 0, 0, 0, 0, 0, 0, 0, "");
        vsync = 1;
        px(0, 128, 1, 0, 0, 0, 0, 0, 0, "");
        repeat (38) px(0, 128, 0, 0, 0, 0, 0, 0, 0, "");
        px(0, 128, 0, 0, 0, 1, 72, 128, 0, "los_pre");
        px(0, 128, 0, 0, 0, 1, 72, 128, 1, "los_edge");
        repeat (3) px(255, 200, 0, 1, 1, 1, 72, 128, 1, "los_hold");
        vsync = 0;
        repeat (2) px(0, 128, 0, 0, 0, 0, 0, 0, 0, "");
        px(0, 128, 1, 0, 0, 1, 72, 128, 0, "los_exit");
        px(0, 128, 1, 1, 0, 1, 54, 128, 0, "los_ramp1");
        px(0, 128, 1, 1, 0, 1, 36, 128, 0, "los_ramp2");
        px(0, 128, 0, 0, 0, 1, 54, 128, 0, "los_rev");
        px(0, 128, 0, 0, 0, 1, 72, 128, 0, "los_blank");
        repeat (4) px(0, 128, 1, 1, 0, 0, 0, 0, 0, "");
        #2 reset_n = 0;
        q.delete();
        #1 check("rst_async", act, {24'h804800, 4'h0});
        @(posedge clk);
        #1 check("rst_edge", act, {24'h804800, 4'h0});
        @(negedge clk);
        hsync = 0;
        csync = 0;
        reset_n = 1;
        repeat (3) px(255, 128, 0, 0, 1, 1, 72, 128, 0, "post_rst_idle");
        px(0, 128, 1, 0, 0, 1, 72, 128, 0, "post_rst_hs");
        px(0, 128, 0, 0, 1, 1, 82, 128, 0, "post_rst_act");
        for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) check("drain", 28'(q.size()), 28'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
